div_iter_param: RTL and testbench
=================================

Name: div_iter_param

Overview:
- Parametrised multi-cycle restoring divider for the execute stage's multiply/divide unit.
- Computes quotient and remainder for signed or unsigned operands of WIDTH bits.
- Retires BITS_PER_CYCLE quotient bits per clock.
- Uses a start/done/ack handshake, supports annul at any time, flags divide-by-zero, and holds its result until acknowledged.

Parameters:
- WIDTH, 32: operand, quotient and remainder width. Must be even and at least 4.
- BITS_PER_CYCLE, 1: quotient bits resolved per CALC cycle. Legal values are 1, 2 and 4; WIDTH must be a multiple of this value.
- CNT_W, $clog2(WIDTH/BITS_PER_CYCLE+1): iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  request; sampled only in IDLE
- signed_i  in  1  1 = two's-complement operation; sampled with start_i
- dividend_i  in  WIDTH  dividend; sampled with start_i
- divisor_i  in  WIDTH  divisor; sampled with start_i
- annul_i  in  1  abort the current operation (pipeline flush)
- ack_i  in  1  consumer accepts the result in DONE
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  result valid; high only in DONE
- quotient_o  out  WIDTH  quotient, valid while done_o
- remainder_o  out  WIDTH  remainder, valid while done_o
- div0_o  out  1  divide-by-zero flag, valid while done_o

Behaviour:

Reset:
- state = IDLE.
- busy_o, done_o and div0_o are 0.
- quotient_o and remainder_o are all zeros.
- A reset mid-operation discards the operation; there is no partial output.

States: IDLE, CALC, FIX, DONE.

IDLE:
- If start_i=1 and annul_i=0, register the operands, signed_i, the dividend sign and the divisor sign.
- Divisor = 0: go to DONE.
- Otherwise: load magnitudes (two's-complement negate when signed_i and MSB=1; a W-bit unsigned magnitude, so the minimum negative value maps to 2^(W-1)), clear the partial remainder and the counter, then go to CALC.
- start_i is ignored outside IDLE.

CALC:
- Each cycle performs BITS_PER_CYCLE chained restoring steps:
  - Shift {rem, quo} left by 1.
  - trial = rem - divisor, computed in W+1 bits.
  - If trial is non-negative, rem = trial and quo LSB = 1; otherwise quo LSB = 0.
- counter++. After WIDTH/BITS_PER_CYCLE cycles, go to FIX.

FIX, 1 cycle:
- If signed and the operand signs differ, quotient = -quotient.
- If signed and the dividend is negative, remainder = -remainder.
- Go to DONE.

DONE:
- done_o=1, with outputs driven from registers.
- The result is held stable until ack_i=1.
- On ack_i=1, return to IDLE the next cycle with done_o=0 and outputs cleared.
- ack_i outside DONE is ignored.

Latency: start accepted at cycle T gives done_o=1 at cycle T + WIDTH/BITS_PER_CYCLE + 2.

Divide-by-zero:
- DONE is reached at T+1 with div0_o=1.
- quotient = all ones, remainder = original dividend_i, in both signed and unsigned modes.

Overflow (signed minimum value / -1):
- No special path. The magnitude arithmetic yields quotient = minimum value and remainder = 0, and div0_o=0.

annul_i:
- In IDLE, annul_i=1 blocks a simultaneous start.
- In CALC or FIX, annul_i=1 returns to IDLE next cycle, with done_o never asserted.
- In DONE, annul_i=1 behaves as ack_i: the result is dropped.
- annul_i has priority over every transition.

Outputs are registered. There is no combinational path from inputs to done_o.

Decomposition:
- Shared package, div_pkg:
  - State encoding constants: DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE.
  - A helper function for two's-complement magnitude/negate.
- Sub-module div_step, combinational, parametrised by WIDTH: one restoring step, taking rem, quo and divisor and producing the next rem and quo.
  - The top instantiates BITS_PER_CYCLE of them in a generate chain.

Test Plan:
- WIDTH=32, BPC=1, unsigned 100/7: q=14, r=2, div0_o=0, done_o exactly at T+34. Result held 5 cycles with ack_i=0, then ack returns to IDLE.
- Signed -7/2 (0xFFFFFFF9 / 0x2): q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Signed 7/-2: q=-3, r=1.
- Divide 0x1234 by 0, signed and unsigned: done_o at T+1, div0_o=1, q=0xFFFFFFFF, r=0x1234.
- Signed 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0. Unsigned 0xFFFFFFFF / 1: q=0xFFFFFFFF, r=0.
- Annul at CALC cycle 10: IDLE next cycle, busy_o=0, no done_o. A new start of 9/3 immediately after gives q=3, r=0.
- BPC=2 and BPC=4, random 1000 operand pairs with ±0, ±1 and extremes, checked against a reference model: latency 18 and 10 respectively, all results match.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// conditional two's-complement helper used for operand magnitudes and result fix-up.
// Contents: div_state_e, DIV_MAX_W, div_cond_neg().
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // The helper works on a fixed wide vector so that any legal WIDTH can use it.
    // Callers zero-extend and keep the low WIDTH bits; negation modulo 2^WIDTH
    // depends only on those low bits. One spare bit beyond the widest
    // supported operand keeps the discarded slice non-empty.
    localparam int DIV_MAX_W = 65;

    // Returns -v when neg is set, v otherwise.
    function automatic logic [DIV_MAX_W-1:0] div_cond_neg(input logic [DIV_MAX_W-1:0] v,
                                                          input logic                 neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift {rem, quo} left, trial-subtract, restore on borrow.
// Purely combinational; chained BITS_PER_CYCLE times by the top.
// Ports: rem_i/quo_i current partial remainder and quotient, dvs_i divisor magnitude,
//        rem_o/quo_o the values after this step.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < dvs always holds, so shifted < 2*dvs. A non-negative trial is then
    // below dvs (< 2^WIDTH) and a negative one is at least -(2^WIDTH-1), so
    // bit WIDTH of a WIDTH+1-bit difference is an exact sign bit.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_i};
        quo_o   = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
        rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_iter_param.sv
// Multi-cycle restoring divider (signed/unsigned), BITS_PER_CYCLE quotient bits per clock.
// Latency: done_o at T+WIDTH/BITS_PER_CYCLE+2 after start accepted at T; T+1 on divide-by-zero.
// Result held in DONE until ack_i (or annul_i); annul_i aborts any state; start_i sampled only in IDLE.
// Ports: clk/rst (sync, active-high); start_i, signed_i, dividend_i, divisor_i request;
//        annul_i flush; ack_i result accept; busy_o, done_o, quotient_o, remainder_o, div0_o.
module div_iter_param
    import div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             annul_i,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div0_o
);

    localparam int                STEPS    = WIDTH / BITS_PER_CYCLE;
    localparam int                CNT_W    = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEPS - 1);

    if (WIDTH < 4 || (WIDTH % 2) != 0 || WIDTH > DIV_MAX_W - 1) begin : g_bad_width
        $error("div_iter_param: WIDTH must be even, >= 4 and <= 64");
    end
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
        (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
        $error("div_iter_param: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
    end

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             sgn_q, dvd_neg_q, dvs_neg_q, div0_q;

    logic                   accept;
    logic                   dvd_is_neg, dvs_is_neg;
    logic [WIDTH-1:0]       dvd_mag, dvs_mag, quo_fix, rem_fix;
    logic [DIV_MAX_W-WIDTH-1:0] dvd_unused, dvs_unused, quo_unused, rem_unused;

    assign accept     = start_i & ~annul_i;
    assign dvd_is_neg = signed_i & dividend_i[WIDTH-1];
    assign dvs_is_neg = signed_i & divisor_i[WIDTH-1];

    // Unsigned WIDTH-bit magnitudes: the most negative value maps to 2^(WIDTH-1).
    // The FIX-stage sign corrections reuse the same helper.
    always_comb begin
        {dvd_unused, dvd_mag} = div_cond_neg(DIV_MAX_W'(dividend_i), dvd_is_neg);
        {dvs_unused, dvs_mag} = div_cond_neg(DIV_MAX_W'(divisor_i), dvs_is_neg);
        {quo_unused, quo_fix} = div_cond_neg(DIV_MAX_W'(quo_q), sgn_q & (dvd_neg_q ^ dvs_neg_q));
        {rem_unused, rem_fix} = div_cond_neg(DIV_MAX_W'(rem_q), sgn_q & dvd_neg_q);
    end

    // Step chain: element 0 is the registered state, element BITS_PER_CYCLE the next.
    logic [WIDTH-1:0] ch_rem [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] ch_quo [BITS_PER_CYCLE+1];

    assign ch_rem[0] = rem_q;
    assign ch_quo[0] = quo_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_i (ch_rem[i]),
            .quo_i (ch_quo[i]),
            .dvs_i (dvs_q),
            .rem_o (ch_rem[i+1]),
            .quo_o (ch_quo[i+1])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= DIV_IDLE;
        else     state_q <= state_d;
    end

    // Next state; annul_i wins over every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (accept) state_d = (divisor_i == '0) ? DIV_DONE : DIV_CALC;
            DIV_CALC: begin
                if (annul_i)                state_d = DIV_IDLE;
                else if (cnt_q == CNT_LAST) state_d = DIV_FIX;
            end
            DIV_FIX:  state_d = annul_i ? DIV_IDLE : DIV_DONE;
            DIV_DONE: if (ack_i || annul_i) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // Datapath. Values left behind by an annulled operation are harmless:
    // outputs are gated by DONE and the next accept reloads everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (accept) begin
                        sgn_q     <= signed_i;
                        dvd_neg_q <= dvd_is_neg;
                        dvs_neg_q <= dvs_is_neg;
                        cnt_q     <= '0;
                        if (divisor_i == '0) begin
                            quo_q  <= '1;
                            rem_q  <= dividend_i;
                            div0_q <= 1'b1;
                        end else begin
                            // Dividend magnitude sits in quo and is shifted out
                            // MSB-first as quotient bits shift in.
                            quo_q  <= dvd_mag;
                            rem_q  <= '0;
                            dvs_q  <= dvs_mag;
                            div0_q <= 1'b0;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_q <= ch_rem[BITS_PER_CYCLE];
                    quo_q <= ch_quo[BITS_PER_CYCLE];
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                DIV_FIX: begin
                    quo_q <= quo_fix;
                    rem_q <= rem_fix;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only; cleared outside DONE.
    always_comb begin
        busy_o      = (state_q != DIV_IDLE);
        done_o      = (state_q == DIV_DONE);
        quotient_o  = (state_q == DIV_DONE) ? quo_q : '0;
        remainder_o = (state_q == DIV_DONE) ? rem_q : '0;
        div0_o      = (state_q == DIV_DONE) & div0_q;
    end

endmodule

// File: tb/tb_div_iter_param.sv
// Bench for div_iter_param: three 32-bit instances (1, 2, 4 bits/cycle) share stimulus.
// Directed vectors with hand-computed results, annul cases, then a randomised sweep
// against a magnitude/sign reference model; prints one pass-count summary line.
module tb_div_iter_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, signed_i, annul_i, ack_i;
    logic [31:0] dividend_i, divisor_i;

    logic        busy_w [3];
    logic        done_w [3];
    logic        div0_w [3];
    logic [31:0] q_w    [3];
    logic [31:0] r_w    [3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        div_iter_param #(.WIDTH(32), .BITS_PER_CYCLE(1 << g)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start_i     (start_i),
            .signed_i    (signed_i),
            .dividend_i  (dividend_i),
            .divisor_i   (divisor_i),
            .annul_i     (annul_i),
            .ack_i       (ack_i),
            .busy_o      (busy_w[g]),
            .done_o      (done_w[g]),
            .quotient_o  (q_w[g]),
            .remainder_o (r_w[g]),
            .div0_o      (div0_w[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: divide magnitudes with the language operators, then apply signs.
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic d);
        logic        an, bn;
        logic [31:0] am, bm;
        logic [63:0] qq, rr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            d = 1'b1;
        end else begin
            an = s & a[31];
            bn = s & b[31];
            am = an ? (32'd0 - a) : a;
            bm = bn ? (32'd0 - b) : b;
            qq = {32'd0, am} / {32'd0, bm};
            rr = {32'd0, am} % {32'd0, bm};
            q  = (an ^ bn) ? (32'd0 - qq[31:0]) : qq[31:0];
            r  = an ? (32'd0 - rr[31:0]) : rr[31:0];
            d  = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'hFFFF_FFFE;
            6:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; issues one request to all instances, measures latency,
    // checks results, optionally checks the hold-until-ack behaviour, then acks.
    task automatic do_op(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic ed, input bit hold);
        int lat [3];
        int exp_lat;
        lat = '{0, 0, 0};
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            for (int i = 0; i < 3; i++)
                if (lat[i] == 0 && done_w[i]) lat[i] = k;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
        end
        for (int i = 0; i < 3; i++) begin
            exp_lat = ed ? 1 : (32 / (1 << i)) + 2;
            chk($sformatf("%s bpc%0d latency", tag, 1 << i), 64'(lat[i]), 64'(exp_lat));
            chk($sformatf("%s bpc%0d quotient", tag, 1 << i), 64'(q_w[i]), 64'(eq));
            chk($sformatf("%s bpc%0d remainder", tag, 1 << i), 64'(r_w[i]), 64'(er));
            chk($sformatf("%s bpc%0d div0", tag, 1 << i), 64'(div0_w[i]), 64'(ed));
        end
        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk($sformatf("%s hold%0d done", tag, k), 64'(done_w[0]), 64'd1);
                chk($sformatf("%s hold%0d quotient", tag, k), 64'(q_w[0]), 64'(eq));
                chk($sformatf("%s hold%0d remainder", tag, k), 64'(r_w[0]), 64'(er));
            end
        end
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s bpc%0d busy after ack", tag, 1 << i), 64'(busy_w[i]), 64'd0);
        if (hold) begin
            chk($sformatf("%s done after ack", tag), 64'(done_w[0]), 64'd0);
            chk($sformatf("%s quotient after ack", tag), 64'(q_w[0]), 64'd0);
            chk($sformatf("%s remainder after ack", tag), 64'(r_w[0]), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] a, b, eq, er;
        logic        s, ed;
        bit          seen_done;

        rst        = 1'b1;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        annul_i    = 1'b0;
        ack_i      = 1'b0;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset bpc%0d busy", 1 << i), 64'(busy_w[i]), 64'd0);
            chk($sformatf("reset bpc%0d done", 1 << i), 64'(done_w[i]), 64'd0);
            chk($sformatf("reset bpc%0d div0", 1 << i), 64'(div0_w[i]), 64'd0);
            chk($sformatf("reset bpc%0d quotient", 1 << i), 64'(q_w[i]), 64'd0);
            chk($sformatf("reset bpc%0d remainder", 1 << i), 64'(r_w[i]), 64'd0);
        end

        // annul in IDLE blocks a simultaneous start
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        start_i    = 1'b1;
        annul_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        chk("idle annul blocks start busy", 64'(busy_w[0]), 64'd0);
        @(negedge clk);

        do_op("u 100/7",         1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b1);
        do_op("s -7/2",          1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0);
        do_op("s 7/-2",          1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0);
        do_op("s 0x1234/0",      1'b1, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 1'b1);
        do_op("u 0x1234/0",      1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 1'b0);
        do_op("s min/-1",        1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b0);
        do_op("u max/1",         1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0);
        do_op("s -100/-7",       1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0);

        // annul during the 10th CALC cycle; the 4-bit/cycle instance is in DONE by
        // then and drops its result instead
        seen_done  = 1'b0;
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divisor_i  = 32'd7;
        start_i    = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (done_w[0] || done_w[1]) seen_done = 1'b1;
            if (k == 10) annul_i = 1'b1;
        end
        @(negedge clk);
        annul_i = 1'b0;
        if (done_w[0] || done_w[1]) seen_done = 1'b1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("annul bpc%0d busy", 1 << i), 64'(busy_w[i]), 64'd0);
        chk("annul done never seen", 64'(seen_done), 64'd0);
        do_op("after annul u 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            a = pick();
            b = pick();
            s = 1'($urandom_range(0, 1));
            model(s, a, b, eq, er, ed);
            do_op($sformatf("rand%0d %s 0x%0h/0x%0h", n, s ? "s" : "u", a, b),
                  s, a, b, eq, er, ed, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
